// File: rtl/booth_r4_seq_mult_if.sv
// Operand/result handshake bundle for booth_r4_seq_mult.
// master = operand producer / result consumer, slave = multiplier.
interface booth_r4_seq_mult_if #(
  parameter int WIDTH = 8
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   prod;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, prod
  );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation,
// valid/ready on both sides, one operation in flight.
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  booth_r4_seq_mult_if.slave bus
);
  localparam int EW = WIDTH + 2;
  localparam int N  = EW / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     m;
  logic [EW:0]       q;
  logic [EW+1:0]     acc;
  logic [CW-1:0]     cnt;
  logic              out_valid_r;
  logic [2*WIDTH-1:0] prod_r;

  logic              accept, finish;
  logic [EW-1:0]     a_ext, b_ext;
  logic [EW+1:0]     m_ext, addend, sum, acc_nxt;
  logic [EW:0]       q_nxt;
  logic [2*EW+1:0]   full;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
        CALC: if (cnt == CW'(N - 1)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
        DONE: if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Extension by two bits keeps unsigned operands positive in signed arithmetic.
  always_comb begin
    a_ext  = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    b_ext  = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
    m_ext  = {{2{m[EW-1]}}, m};
    addend = '0;
    case (q[2:0])
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum     = acc + addend;
    acc_nxt = {{2{sum[EW+1]}}, sum[EW+1:2]};
    q_nxt   = {sum[1:0], q[EW:2]};
    full    = {acc_nxt, q_nxt[EW:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      m           <= '0;
      q           <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      prod_r      <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        cnt         <= '0;
        out_valid_r <= 1'b0;
      end else if (accept) begin
        m   <= a_ext;
        q   <= {b_ext, 1'b0};
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        q   <= q_nxt;
        cnt <= cnt + CW'(1);
        if (finish) begin
          prod_r      <= full[2*WIDTH-1:0];
          out_valid_r <= 1'b1;
        end
      end else if (state == DONE && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.prod      = prod_r;
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench: vector table plus scoreboard queues for WIDTH=8 and WIDTH=16,
// with hand-written backpressure, async reset and clr sequences.
module tb_booth_r4_seq_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  booth_r4_seq_mult_if #(.WIDTH(8))  if8 ();
  booth_r4_seq_mult_if #(.WIDTH(16)) if16 ();

  booth_r4_seq_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if8.slave));
  booth_r4_seq_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if16.slave));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[13];
  logic [15:0] sb8[$];
  logic [31:0] sb16[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input string nm);
    int t, edges;
    logic [15:0] e;
    @(negedge clk);
    if8.a = a; if8.b = b; if8.is_signed = s; if8.in_valid = 1'b1;
    t = 0;
    while (!if8.in_ready && t < 50) begin @(negedge clk); t++; end
    check({nm, " accept"}, {31'd0, if8.in_ready}, 32'd1);
    @(posedge clk);
    sb8.push_back(exp);
    @(negedge clk);
    if8.in_valid = 1'b0; if8.a = ~a; if8.b = ~b; if8.is_signed = ~s;
    edges = 0;
    do begin @(posedge clk); edges++; @(negedge clk); end
    while (!if8.out_valid && edges < 40);
    check({nm, " latency"}, edges, 32'd5);
    if (sb8.size() == 0) check({nm, " scoreboard empty"}, 32'd0, 32'd1);
    else begin
      e = sb8.pop_front();
      check({nm, " prod"}, {16'd0, if8.prod}, {16'd0, e});
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.out_ready = 1'b0;
    check({nm, " out_valid cleared"}, {31'd0, if8.out_valid}, 32'd0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [31:0] exp, input string nm);
    int edges;
    @(negedge clk);
    if16.a = a; if16.b = b; if16.is_signed = s; if16.in_valid = 1'b1;
    check({nm, " ready"}, {31'd0, if16.in_ready}, 32'd1);
    @(posedge clk);
    sb16.push_back(exp);
    @(negedge clk);
    if16.in_valid = 1'b0;
    edges = 0;
    do begin @(posedge clk); edges++; @(negedge clk); end
    while (!if16.out_valid && edges < 40);
    check({nm, " latency"}, edges, 32'd9);
    if (sb16.size() == 0) check({nm, " scoreboard empty"}, 32'd0, 32'd1);
    else check({nm, " prod"}, if16.prod, sb16.pop_front());
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rs;
    logic [15:0] rexp, held;
    logic [15:0] r16a, r16b;
    logic [31:0] r16e;
    int          t;

    vecs[0]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[3]  = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
    vecs[4]  = '{8'h07, 8'h06, 1'b0, 16'h002A};
    vecs[5]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    vecs[6]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[8]  = '{8'h00, 8'h55, 1'b1, 16'h0000};
    vecs[9]  = '{8'hAA, 8'h55, 1'b0, 16'h3872};
    vecs[10] = '{8'hAA, 8'h55, 1'b1, 16'hE372};
    vecs[11] = '{8'h01, 8'hFF, 1'b0, 16'h00FF};
    vecs[12] = '{8'h01, 8'hFF, 1'b1, 16'hFFFF};

    if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.is_signed = 1'b0;  if8.out_ready = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.is_signed = 1'b0; if16.out_ready = 1'b0;

    #22 rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", {31'd0, if8.in_ready}, 32'd1);
    check("reset out_valid", {31'd0, if8.out_valid}, 32'd0);
    check("reset prod", {16'd0, if8.prod}, 32'd0);
    check("reset prod16", if16.prod, 32'd0);

    for (int i = 0; i < 13; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      rexp = rs ? 16'($signed(ra) * $signed(rb)) : 16'(ra * rb);
      op8(ra, rb, rs, rexp, $sformatf("rnd%0d", i));
    end

    op16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16 min*max");
    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 unsigned max");
    for (int i = 0; i < 4; i++) begin
      r16a = 16'($urandom); r16b = 16'($urandom); rs = 1'($urandom);
      r16e = rs ? 32'($signed(r16a) * $signed(r16b)) : 32'(r16a * r16b);
      op16(r16a, r16b, rs, r16e, $sformatf("w16 rnd%0d", i));
    end

    // Backpressure with in_valid held high throughout.
    @(negedge clk);
    if8.a = 8'h0D; if8.b = 8'h0B; if8.is_signed = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk);
    sb8.push_back(16'd143);
    t = 0;
    do begin @(negedge clk); t++; end while (!if8.out_valid && t < 40);
    check("bp first result", {16'd0, if8.prod}, {16'd0, sb8.pop_front()});
    held = if8.prod;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp prod stable", {16'd0, if8.prod}, {16'd0, held});
      check("bp out_valid held", {31'd0, if8.out_valid}, 32'd1);
      check("bp in_ready low", {31'd0, if8.in_ready}, 32'd0);
    end
    if8.out_ready = 1'b1;
    @(posedge clk);
    sb8.push_back(16'd143);
    @(negedge clk);
    if8.out_ready = 1'b0;
    check("bp idle after handshake", {31'd0, if8.in_ready}, 32'd1);
    check("bp out_valid dropped", {31'd0, if8.out_valid}, 32'd0);
    @(negedge clk);
    if8.in_valid = 1'b0;
    check("bp second accept", {31'd0, if8.in_ready}, 32'd0);
    t = 0;
    while (!if8.out_valid && t < 40) begin @(negedge clk); t++; end
    check("bp second result", {16'd0, if8.prod}, {16'd0, sb8.pop_front()});
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.out_ready = 1'b0;

    // Asynchronous reset pulse in the third CALC cycle.
    @(negedge clk);
    if8.a = 8'h55; if8.b = 8'h33; if8.is_signed = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk);
    sb8.push_back(16'h10EF);
    @(negedge clk);
    if8.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", {31'd0, if8.out_valid}, 32'd0);
    check("async rst prod", {16'd0, if8.prod}, 32'd0);
    check("async rst in_ready", {31'd0, if8.in_ready}, 32'd1);
    #2 rst_n = 1'b1;
    void'(sb8.pop_back());
    op8(8'd7, 8'd6, 1'b0, 16'h002A, "after reset");

    // clr together with in_valid in IDLE blocks the accept.
    @(negedge clk);
    if8.a = 8'h10; if8.b = 8'h10; if8.in_valid = 1'b1; clr = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0; clr = 1'b0;
    check("clr idle no accept", {31'd0, if8.in_ready}, 32'd1);

    // clr mid-CALC aborts and keeps the previous product.
    held = if8.prod;
    @(negedge clk);
    if8.a = 8'h21; if8.b = 8'h03; if8.is_signed = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk);
    sb8.push_back(16'h0063);
    @(negedge clk);
    if8.in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    void'(sb8.pop_back());
    check("clr calc to idle", {31'd0, if8.in_ready}, 32'd1);
    t = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if8.out_valid) t++;
    end
    check("clr out_valid never", t, 32'd0);
    check("clr prod retained", {16'd0, if8.prod}, {16'd0, held});

    op8(8'hC3, 8'h5A, 1'b1, 16'($signed(8'hC3) * $signed(8'h5A)), "after clr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
